// File: rtl/joy_pkg.sv
// Shared constants for the joystick serial-chain scanner: FSM state encodings
// and default timing for a 50 MHz board clock.
package joy_pkg;

  localparam logic [2:0] ST_GAP   = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_PASS  = 3'd4;

  localparam int JOY_HALF     = 25;     // clk50mhz cycles per joy_clk half-period
  localparam int JOY_NBITS    = 16;     // two cascaded 8-bit 165s
  localparam int JOY_SCAN_GAP = 50000;  // 1 ms between scans

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer with a configurable reset value, for asynchronous
// board-level inputs.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/joy_scan_ctrl.sv
// Joystick chain sequencer: periodically loads and shifts two cascaded 165s and
// publishes active-high button words, or hands the chain to an external master.
module joy_scan_ctrl
  import joy_pkg::*;
#(
  parameter int HALF     = JOY_HALF,
  parameter int NBITS    = JOY_NBITS,
  parameter int SCAN_GAP = JOY_SCAN_GAP
) (
  input  logic               clk50mhz,
  input  logic               reset_n,
  input  logic               passthru,
  input  logic               joy_data,
  input  logic               xjoy_clk,
  input  logic               xjoy_load_n,
  output logic               joy_clk,
  output logic               joy_load_n,
  output logic               xjoy_data,
  output logic [NBITS/2-1:0] joy1,
  output logic [NBITS/2-1:0] joy2,
  output logic               joy_valid,
  output logic               busy,
  output logic [2:0]         dbg_state
);

  localparam int GW = $clog2(SCAN_GAP);
  localparam int HW = $clog2(HALF);
  localparam int BW = $clog2(NBITS);
  localparam logic [GW-1:0] GAP_LAST  = GW'(SCAN_GAP - 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NBITS - 1);

  logic [2:0]       state;
  logic [GW-1:0]    gap_cnt;
  logic [HW-1:0]    half_cnt;
  logic [BW-1:0]    bit_cnt;
  logic             clk_r;
  logic [NBITS-1:0] shreg;
  logic             data_s;
  logic             pass_s;
  logic             in_pass;

  sync2 #(.RST_VAL(1'b1)) u_sync_data (
    .clk     (clk50mhz),
    .reset_n (reset_n),
    .d       (joy_data),
    .q       (data_s)
  );

  sync2 #(.RST_VAL(1'b0)) u_sync_pass (
    .clk     (clk50mhz),
    .reset_n (reset_n),
    .d       (passthru),
    .q       (pass_s)
  );

  // joy_valid is a one-cycle strobe with no ready: joy1/joy2 change in the same
  // cycle it is high and then hold until the next completed scan.
  always_ff @(posedge clk50mhz) begin
    if (!reset_n) begin
      state     <= ST_GAP;
      gap_cnt   <= '0;
      half_cnt  <= '0;
      bit_cnt   <= '0;
      clk_r     <= 1'b0;
      shreg     <= '0;
      joy1      <= '0;
      joy2      <= '0;
      joy_valid <= 1'b0;
    end else begin
      joy_valid <= 1'b0;
      case (state)
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt  <= '0;
            half_cnt <= '0;
            state    <= pass_s ? ST_PASS : ST_LOAD;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        ST_LOAD: begin
          if (half_cnt == HALF_LAST) begin
            half_cnt <= '0;
            bit_cnt  <= '0;
            clk_r    <= 1'b0;
            state    <= ST_SHIFT;
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (half_cnt == HALF_LAST) begin
            half_cnt <= '0;
            if (!clk_r) begin
              // Last low-phase cycle: data is stable, sample before the rise.
              shreg <= {shreg[NBITS-2:0], data_s};
              if (bit_cnt == BIT_LAST) begin
                state <= ST_DONE;
              end else begin
                clk_r <= 1'b1;
              end
            end else begin
              clk_r   <= 1'b0;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          joy1      <= ~shreg[NBITS-1:NBITS/2];
          joy2      <= ~shreg[NBITS/2-1:0];
          joy_valid <= 1'b1;
          clk_r     <= 1'b0;
          gap_cnt   <= '0;
          state     <= ST_GAP;
        end
        ST_PASS: begin
          if (!pass_s) begin
            gap_cnt <= '0;
            state   <= ST_GAP;
          end
        end
        default: begin
          gap_cnt <= '0;
          state   <= ST_GAP;
        end
      endcase
    end
  end

  // Passthrough is decided by the registered state, so the pins only switch
  // owner on a scan boundary.
  assign in_pass    = (state == ST_PASS);
  assign joy_clk    = in_pass ? xjoy_clk : clk_r;
  assign joy_load_n = in_pass ? xjoy_load_n : (state != ST_LOAD);
  assign xjoy_data  = in_pass ? joy_data : 1'b1;
  assign busy       = (state == ST_LOAD) || (state == ST_SHIFT);
  assign dbg_state  = state;

endmodule
